fpu_wb_queue: RTL

- Sits directly downstream of the pipelined FPU (`fpu_pipe`).
- Records the destination tag of every operation issued into the FPU and pairs each FPU result, in order, with its tag.
- Buffers tagged results and presents them to register-file writeback over a valid/ready handshake.
- The FPU pipe cannot stall, so issue is credit-gated: a result always has a buffer slot when it emerges.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fpu_sync_fifo.sv | 49 ++++
 rtl/fpu_wb_queue.sv | 87 ++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared widths and tag layout for the FPU writeback path.
// A tag is {to_int, rd}; a buffered result entry is {data, tag}.
package fpu_pkg;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned TAG_W   = REG_W + 1;
   localparam int unsigned ENTRY_W = DATA_W + TAG_W;

   typedef struct packed {
      logic             to_int;
      logic [REG_W-1:0] rd;
   } tag_t;
endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO with head-of-queue read port and occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fpu_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
            wptr              <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
      end
   end

   assign dout  = mem[rptr[AW-1:0]];
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// File: rtl/fpu_wb_queue.sv
// Pairs in-order FPU results with their issue-time destination tags and
// buffers them for writeback; issue is credit-gated so results never overflow.
module fpu_wb_queue
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [REG_W-1:0]  issue_rd,
   input  logic              issue_to_int,
   input  logic [DATA_W-1:0] fpu_res,
   input  logic              fpu_valid,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_W-1:0]  wb_rd,
   output logic              wb_to_int,
   output logic [CNT_W-1:0]  inflight,
   output logic              busy,
   output logic              err_orphan
);
   tag_t               tag_in;
   tag_t               wb_tag;
   logic [TAG_W-1:0]   tag_head;
   logic [ENTRY_W-1:0] res_head;
   logic               tag_push, tag_full, tag_empty;
   logic               res_push, res_pop, res_full, res_empty;
   logic [CNT_W-1:0]   tag_cnt, res_cnt;
   logic [CNT_W:0]     used;

   assign tag_in   = '{to_int: issue_to_int, rd: issue_rd};
   assign tag_push = issue_valid && issue_ready;
   // A result with no outstanding tag is dropped rather than paired with a same-cycle issue.
   assign res_push = fpu_valid && !tag_empty;
   assign res_pop  = wb_valid && wb_ready;

   fpu_sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_push),
      .din   (tag_in),
      .pop   (res_push),
      .dout  (tag_head),
      .full  (tag_full),
      .empty (tag_empty),
      .count (tag_cnt)
   );

   fpu_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (res_push),
      .din   ({fpu_res, tag_head}),
      .pop   (res_pop),
      .dout  (res_head),
      .full  (res_full),
      .empty (res_empty),
      .count (res_cnt)
   );

   // Credits come from registered counts only; a same-cycle wb pop is not counted.
   assign used        = {1'b0, tag_cnt} + {1'b0, res_cnt};
   assign issue_ready = (used < (CNT_W + 1)'(DEPTH));

   assign wb_valid  = !res_empty;
   assign wb_data   = res_head[ENTRY_W-1 -: DATA_W];
   assign wb_tag    = res_head[TAG_W-1:0];
   assign wb_rd     = wb_tag.rd;
   assign wb_to_int = wb_tag.to_int;
   assign inflight  = tag_cnt;
   assign busy      = !tag_empty || !res_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_orphan <= 1'b0;
      end else if (fpu_valid && tag_empty) begin
         err_orphan <= 1'b1;
      end
   end

   a_no_res_overflow: assert property (@(posedge clk) disable iff (rst) !(res_push && res_full));
   a_no_tag_overflow: assert property (@(posedge clk) disable iff (rst) !(tag_push && tag_full));
endmodule
